// File: rtl/pc_unit_vliw.sv
// Bundle program counter with priority redirect (flush > stall > ret > call > branch) and a
// circular return-address stack. Define PC_ALIGN_CHK_EN to trap misaligned targets to TRAP_VEC.
module pc_unit_vliw #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       BUNDLE_BYTES = 8,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int unsigned       RAS_DEPTH    = 4,
    parameter logic [ADDR_W-1:0] TRAP_VEC     = 'h80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              ret,
    input  logic              call,
    input  logic [ADDR_W-1:0] call_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_seq,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_udf,
    output logic              align_fault
);

    localparam int unsigned       PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned       CNT_W    = PTR_W + 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BUNDLE_BYTES - 1);

    logic [ADDR_W-1:0] pc_q, pc_d, tgt;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, top_idx;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q, udf_q, udf_d, fault_q, fault_d;
    logic              push, pop, tgt_sel;

    assign pc          = pc_q;
    assign pc_seq      = pc_q + ADDR_W'(BUNDLE_BYTES);
    assign ras_empty   = (cnt_q == '0);
    assign ras_full    = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_ovf     = ovf_q;
    assign ras_udf     = udf_q;
    assign align_fault = fault_q;
    // ptr_q addresses the next free slot; the top of stack sits just below it
    assign top_idx     = ptr_q - PTR_W'(1);

    always_comb begin
        pc_d    = pc_q;
        tgt     = '0;
        tgt_sel = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        udf_d   = 1'b0;
        fault_d = 1'b0;
        if (flush) begin
            tgt     = flush_pc;
            tgt_sel = 1'b1;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (!ras_empty) begin
                tgt     = ras_q[top_idx];
                tgt_sel = 1'b1;
                pop     = 1'b1;
            end else begin
                pc_d  = pc_seq;
                udf_d = 1'b1;
            end
        end else if (call) begin
            tgt     = call_target;
            tgt_sel = 1'b1;
            push    = 1'b1;
        end else if (branch_taken) begin
            tgt     = branch_target;
            tgt_sel = 1'b1;
        end else begin
            pc_d = pc_seq;
        end

        if (tgt_sel) begin
`ifdef PC_ALIGN_CHK_EN
            if ((tgt & OFF_MASK) != '0) begin
                pc_d    = TRAP_VEC;
                fault_d = 1'b1;
            end else begin
                pc_d = tgt;
            end
`else
            pc_d = tgt & ~OFF_MASK;
`endif
        end
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            udf_q   <= udf_d;
            fault_q <= fault_d;
            if (push) begin
                // when full, ptr_q already points at the oldest entry, which gets overwritten
                ptr_q <= ptr_q + PTR_W'(1);
                if (ras_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (pop) begin
                ptr_q <= top_idx;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(negedge clk) begin
        if (reset && push) begin
            ras_q[ptr_q] <= pc_seq;
        end
    end

endmodule

// File: tb/tb_pc_unit_vliw.sv
// Randomised scoreboard bench for pc_unit_vliw; honours PC_ALIGN_CHK_EN like the design.
module tb_pc_unit_vliw;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] TRAP  = 32'h80;

    logic        clk = 1'b1;
    logic        reset, stall, flush, ret, call, branch_taken;
    logic [31:0] flush_pc, call_target, branch_target;
    logic [31:0] pc, pc_seq;
    logic        ras_empty, ras_full, ras_ovf, ras_udf, align_fault;

    always #5 clk = ~clk;

    pc_unit_vliw dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .ret          (ret),
        .call         (call),
        .call_target  (call_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .pc           (pc),
        .pc_seq       (pc_seq),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_ovf      (ras_ovf),
        .ras_udf      (ras_udf),
        .align_fault  (align_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        udf;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: PC as a number, RAS as a bounded queue (newest at the back)
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    bit          m_ovf, m_udf, m_fault;

    task automatic load(input logic [31:0] t);
`ifdef PC_ALIGN_CHK_EN
        if (t % 8 != 0) begin
            m_pc    = TRAP;
            m_fault = 1'b1;
        end else begin
            m_pc = t;
        end
`else
        m_pc = (t / 8) * 8;
`endif
    endtask

    task automatic step(input logic rst, input logic fl, input logic st, input logic rt,
                        input logic cl, input logic br, input logic [31:0] fpc,
                        input logic [31:0] ct, input logic [31:0] bt);
        exp_t e;
        reset = rst; flush = fl; stall = st; ret = rt; call = cl; branch_taken = br;
        flush_pc = fpc; call_target = ct; branch_target = bt;
        m_udf   = 1'b0;
        m_fault = 1'b0;
        if (!rst) begin
            m_pc = 32'h0;
            m_ras.delete();
            m_ovf = 1'b0;
        end else if (fl) begin
            load(fpc);
        end else if (st) begin
            m_pc = m_pc;
        end else if (rt) begin
            if (m_ras.size() > 0) begin
                load(m_ras.pop_back());
            end else begin
                m_pc  = m_pc + 32'd8;
                m_udf = 1'b1;
            end
        end else if (cl) begin
            if (m_ras.size() == DEPTH) begin
                void'(m_ras.pop_front());
                m_ovf = 1'b1;
            end
            m_ras.push_back(m_pc + 32'd8);
            load(ct);
        end else if (br) begin
            load(bt);
        end else begin
            m_pc = m_pc + 32'd8;
        end
        e.pc    = m_pc;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == DEPTH);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        e.fault = m_fault;
        exp_q.push_back(e);
        @(negedge clk);
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: every falling edge the DUT presents a new state; compare against the queue
    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_seq", pc_seq, e.pc + 32'd8);
            chk("ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
            chk("ras_full", {31'b0, ras_full}, {31'b0, e.full});
            chk("ras_ovf", {31'b0, ras_ovf}, {31'b0, e.ovf});
            chk("ras_udf", {31'b0, ras_udf}, {31'b0, e.udf});
            chk("align_fault", {31'b0, align_fault}, {31'b0, e.fault});
        end
    end

    initial begin
        int wait_cnt;
        // Reset, then free-run: 0x00, 0x08, 0x10
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Stall at 0x10 for two edges, then resume
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        // At 0x20: call 0x100, then return to 0x28
        step(1, 0, 0, 0, 1, 0, 0, 32'h100, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0);
        // Five calls overflow a 4-deep RAS; five rets, the last underflows
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 0, 0, 32'h1000 + 32'h100 * i, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 0, 0, 0, 0);
        // ret+call together: ret wins, no push (RAS empty -> underflow)
        step(1, 0, 0, 1, 1, 1, 0, 32'h2000, 32'h3000);
        // Two calls, then flush during stall with ret: RAS count unchanged
        step(1, 0, 0, 0, 1, 0, 0, 32'h200, 0);
        step(1, 0, 0, 0, 1, 0, 0, 32'h300, 0);
        step(1, 1, 1, 1, 0, 0, 32'h400, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0);
        // Wrap from the top of the address space
        step(1, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 0, 0);
        idle(1);
        // Misaligned branch target
        step(1, 0, 0, 0, 0, 1, 0, 0, 32'h104);
        idle(1);
        // Reset mid-redirect
        step(0, 1, 0, 0, 1, 1, 32'h500, 32'h600, 32'h700);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            logic [31:0] t0, t1, t2;
            r  = $urandom_range(0, 99);
            t0 = $urandom();
            t1 = $urandom();
            t2 = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                t0 &= 32'hFFFF_FFF8; t1 &= 32'hFFFF_FFF8; t2 &= 32'hFFFF_FFF8;
            end
            step(r != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, t0, t1, t2);
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            #3;
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
